// File: rtl/nanoboot_mem_loader.sv
// nanoboot_mem_loader
// Pulls a boot image byte-by-byte from the nanofs file reader, packs bytes
// little-endian into 32-bit words and writes them to instruction memory from
// word address 0 upward. Holds the soft CPU in reset until the image has been
// written, and flags an error if the image does not fit in memory.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle pulse, begins a load from idle
//   fs_start          one-cycle start pulse to the file reader
//   fs_busy, fs_eof   reader status; a byte is valid when both are low
//   fs_byte           reader byte data
//   fs_req_byte       one-cycle pulse consuming the current byte
//   mem_we, mem_addr, mem_wdata, mem_be   instruction-memory write port
//   cpu_reset         high holds the CPU in reset
//   done, error       sticky load-complete / overflow flags
//   words_written     number of words written so far
//   checksum          16-bit byte sum (only with NANOBOOT_CHECKSUM_EN)
//
// Build option: define NANOBOOT_CHECKSUM_EN to build the byte checksum;
// otherwise checksum is tied to zero.
module nanoboot_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  fs_start,
    input  logic                  fs_busy,
    input  logic                  fs_eof,
    input  logic [7:0]            fs_byte,
    output logic                  fs_req_byte,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic [15:0]           checksum
);

    typedef enum logic [3:0] {
        StIdle, StKick, StSettle, StWaitByte, StReq, StGap, StWrite, StFlush, StDone, StError
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0][7:0]       lanes_q, lanes_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  mem_full;
    logic [3:0]            flush_be;

    // Once every word of the memory has been written the count's top bit is
    // set; any further write would overflow.
    assign mem_full      = words_q[ADDR_WIDTH];
    assign mem_addr      = addr_q;
    assign words_written = words_q;

    always_comb begin
        unique case (idx_q)
            2'd1:    flush_be = 4'b0001;
            2'd2:    flush_be = 4'b0011;
            2'd3:    flush_be = 4'b0111;
            default: flush_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            lanes_q <= '0;
            addr_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            addr_q  <= addr_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lanes_d     = lanes_q;
        addr_d      = addr_q;
        words_d     = words_q;
        fs_start    = 1'b0;
        fs_req_byte = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        mem_be      = '0;
        done        = 1'b0;
        error       = 1'b0;
        cpu_reset   = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StKick;
            end
            StKick: begin
                fs_start = 1'b1;
                idx_d    = '0;
                addr_d   = '0;
                words_d  = '0;
                state_d  = StSettle;
            end
            StSettle: state_d = StWaitByte;
            StWaitByte: begin
                // End of file wins over a simultaneous valid byte.
                if (fs_eof) begin
                    state_d = StFlush;
                end else if (!fs_busy) begin
                    lanes_d[idx_q] = fs_byte;
                    state_d        = StReq;
                end
            end
            StReq: begin
                fs_req_byte = 1'b1;
                idx_d       = idx_q + 2'd1;
                state_d     = (idx_q == 2'd3) ? StWrite : StGap;
            end
            // Dead cycle: the reader's busy is registered and may still read
            // low here, so the byte lines must not be sampled.
            StGap: state_d = StWaitByte;
            StWrite: begin
                if (mem_full) begin
                    state_d = StError;
                end else begin
                    mem_we    = 1'b1;
                    mem_be    = 4'hF;
                    mem_wdata = lanes_q;
                    addr_d    = (addr_q == LastAddr) ? addr_q : addr_q + 1'b1;
                    words_d   = words_q + 1'b1;
                    state_d   = StGap;
                end
            end
            StFlush: begin
                if (idx_q == 2'd0) begin
                    state_d = StDone;
                end else if (mem_full) begin
                    state_d = StError;
                end else begin
                    mem_we = 1'b1;
                    mem_be = flush_be;
                    for (int i = 0; i < 4; i++) begin
                        mem_wdata[8*i +: 8] = flush_be[i] ? lanes_q[i] : FILL_BYTE;
                    end
                    addr_d  = (addr_q == LastAddr) ? addr_q : addr_q + 1'b1;
                    words_d = words_q + 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            StError: begin
                error = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef NANOBOOT_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == StKick) begin
            checksum_d = '0;
        end else if (state_q == StReq) begin
            checksum_d = checksum_q + {8'h00, lanes_q[idx_q]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) checksum_q <= '0;
        else       checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
